sw_debounce: RTL and testbench



---
 rtl/sw_debounce_bit.sv | 85 ++++++++
 rtl/sw_debounce.sv | 74 +++++++
 tb/tb_sw_debounce.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer, tick-qualified stability counter and
// debounced output flop. upd_o flags the edge on which the output will change.
module sw_debounce_bit #(
  parameter int STABLE_TICKS = 10
) (
  input  logic wb_clk_i,
  input  logic rst_,
  input  logic tick_i,
  input  logic raw_i,
  output logic sw_o,
  output logic upd_o
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_s;
  state_e           state_s;

  // The state is fully implied by whether the synchronized input matches the output.
  always_comb begin
    if (sync2_q != sw_q) begin
      state_s = ST_COUNTING;
    end else begin
      state_s = ST_STABLE;
    end
  end

  // Next-state logic: any cycle of agreement restarts qualification.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    sw_d    = sw_q;
    cnt_d   = cnt_q;
    upd_s   = 1'b0;
    case (state_s)
      ST_STABLE: begin
        cnt_d = {CNT_W{1'b0}};
      end
      ST_COUNTING: begin
        if (tick_i) begin
          if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
            sw_d  = sync2_q;
            cnt_d = {CNT_W{1'b0}};
            upd_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Synchronizer and output reset high to match an idle (pulled-up) switch.
  always_ff @(posedge wb_clk_i or negedge rst_) begin
    if (!rst_) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sw_q    <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o  = sw_q;
  assign upd_o = upd_s;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning for the GPIO slave: per-bit sync + debounce against a
// shared free-running tick, plus a change pulse and sticky change mask.
module sw_debounce #(
  parameter int WIDTH        = 8,
  parameter int CLK_DIV      = 25000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             wb_clk_i,
  input  logic             rst_,
  input  logic [WIDTH-1:0] sw_raw_,
  input  logic             clr_i,
  output logic [WIDTH-1:0] sw_,
  output logic             chg_o,
  output logic [WIDTH-1:0] chg_mask_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  logic [WIDTH-1:0] upd_s;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  // Prescaler free-runs regardless of switch activity.
  always_comb begin
    tick_s = (div_q == DIV_W'(CLK_DIV - 1));
    if (tick_s) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .wb_clk_i(wb_clk_i),
      .rst_    (rst_),
      .tick_i  (tick_s),
      .raw_i   (sw_raw_[g]),
      .sw_o    (sw_[g]),
      .upd_o   (upd_s[g])
    );
  end

  // A clear coinciding with an update keeps only the bits updating now.
  always_comb begin
    chg_d = |upd_s;
    if (clr_i) begin
      mask_d = upd_s;
    end else begin
      mask_d = mask_q | upd_s;
    end
  end

  // Prescaler, change pulse and sticky mask registers.
  always_ff @(posedge wb_clk_i or negedge rst_) begin
    if (!rst_) begin
      div_q  <= {DIV_W{1'b0}};
      chg_q  <= 1'b0;
      mask_q <= {WIDTH{1'b0}};
    end else begin
      div_q  <= div_d;
      chg_q  <= chg_d;
      mask_q <= mask_d;
    end
  end

  assign chg_o      = chg_q;
  assign chg_mask_o = mask_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with CLK_DIV=4, STABLE_TICKS=3; the bench
// tracks clock edges since reset to predict the exact update edge.
module tb_sw_debounce;

  localparam int WIDTH        = 8;
  localparam int CLK_DIV      = 4;
  localparam int STABLE_TICKS = 3;

  logic             wb_clk_i;
  logic             rst_;
  logic [WIDTH-1:0] sw_raw_;
  logic             clr_i;
  logic [WIDTH-1:0] sw_;
  logic             chg_o;
  logic [WIDTH-1:0] chg_mask_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  sw_debounce #(
    .WIDTH       (WIDTH),
    .CLK_DIV     (CLK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .rst_      (rst_),
    .sw_raw_   (sw_raw_),
    .clr_i     (clr_i),
    .sw_       (sw_),
    .chg_o     (chg_o),
    .chg_mask_o(chg_mask_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Edge count since reset release; tick edges are the multiples of CLK_DIV.
  always @(posedge wb_clk_i or negedge rst_) begin
    if (!rst_) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 500) begin
      step();
      guard++;
    end
    if (cyc != target) check_eq("wait_timeout", 8'(cyc), 8'(target));
  endtask

  // Raw driven just after edge d reaches sync at d+2; update lands on the
  // STABLE_TICKS-th tick edge strictly after that.
  function automatic int upd_edge(input int d);
    int first;
    first = ((d + 2) / CLK_DIV + 1) * CLK_DIV;
    return first + (STABLE_TICKS - 1) * CLK_DIV;
  endfunction

  task automatic drive_update(input string tag, input logic [7:0] raw, input logic [7:0] old_sw,
                              input logic [7:0] new_sw, input logic [7:0] exp_mask, input logic clr_at);
    int u;
    sw_raw_ = raw;
    u = upd_edge(cyc);
    wait_until(u - 1);
    check_eq({tag, "_early_sw"}, sw_, old_sw);
    if (clr_at) clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check_eq({tag, "_sw"}, sw_, new_sw);
    check_eq({tag, "_chg"}, {7'd0, chg_o}, 8'h01);
    check_eq({tag, "_mask"}, chg_mask_o, exp_mask);
    step();
    check_eq({tag, "_chg_once"}, {7'd0, chg_o}, 8'h00);
  endtask

  initial begin
    logic [7:0] sw_acc;
    logic       chg_acc;

    rst_    = 1'b0;
    sw_raw_ = 8'h00;
    clr_i   = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_eq("rst_sw", sw_, 8'hFF);
    check_eq("rst_chg", {7'd0, chg_o}, 8'h00);
    check_eq("rst_mask", chg_mask_o, 8'h00);
    sw_raw_ = 8'hFF;
    #2 rst_ = 1'b1;
    step();
    step();

    drive_update("press", 8'hFE, 8'hFF, 8'hFE, 8'h01, 1'b0);
    repeat (3) step();
    drive_update("release", 8'hFF, 8'hFE, 8'hFF, 8'h01, 1'b0);
    repeat (5) step();
    drive_update("press2", 8'hFE, 8'hFF, 8'hFE, 8'h01, 1'b0);
    repeat (2) step();
    drive_update("clr_vs_set", 8'hFA, 8'hFE, 8'hFA, 8'h04, 1'b1);
    step();
    check_eq("mask_hold", chg_mask_o, 8'h04);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check_eq("clr_only", chg_mask_o, 8'h00);

    // Async reset mid-cycle while sw_ is away from its reset value.
    step();
    #2 rst_ = 1'b0;
    #1;
    check_eq("arst_sw", sw_, 8'hFF);
    check_eq("arst_chg", {7'd0, chg_o}, 8'h00);
    check_eq("arst_mask", chg_mask_o, 8'h00);
    sw_raw_ = 8'hFF;
    repeat (2) @(posedge wb_clk_i);
    #2 rst_ = 1'b1;
    step();
    step();

    sw_acc  = 8'hFF;
    chg_acc = 1'b0;
    for (int r = 0; r < 3; r++) begin
      sw_raw_ = 8'hFD;
      for (int k = 0; k < 6; k++) begin
        step();
        sw_acc  = sw_acc & sw_;
        chg_acc = chg_acc | chg_o;
      end
      sw_raw_ = 8'hFF;
      for (int k = 0; k < 6; k++) begin
        step();
        sw_acc  = sw_acc & sw_;
        chg_acc = chg_acc | chg_o;
      end
    end
    for (int k = 0; k < 16; k++) begin
      step();
      sw_acc  = sw_acc & sw_;
      chg_acc = chg_acc | chg_o;
    end
    check_eq("bounce_sw", sw_acc, 8'hFF);
    check_eq("bounce_chg", {7'd0, chg_acc}, 8'h00);
    check_eq("bounce_mask", chg_mask_o, 8'h00);

    drive_update("multi", 8'h0F, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    repeat (4) step();
    check_eq("multi_hold", sw_, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
